// File: rtl/display_scheduler.sv
// Display scheduler: rotates four 32-bit debug sources across the 7-segment
// digit driver, one halfword page at a time, and generates the scan clock.
module display_scheduler #(
  parameter int SCAN_DIV  = 50_000,
  parameter int DWELL     = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] src_data,
  input  logic [3:0]   src_valid,
  input  logic         auto_mode,
  input  logic         btn_next,
  output logic [31:0]  disp_data,
  output logic         hi_lo,
  output logic         scan_clk,
  output logic [1:0]   cur_src,
  output logic         blank
);

  localparam int SCAN_W  = $clog2(SCAN_DIV) + 1;
  localparam int DWELL_W = $clog2(DWELL) + 1;
  localparam int DB_W    = $clog2(DB_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_LO = 2'd1,
    SHOW_HI = 2'd2
  } stateE;

  stateE               state, stateNext;
  logic [1:0]          srcNext;
  logic [SCAN_W-1:0]   scanCnt;
  logic [DWELL_W-1:0]  dwellCnt;
  logic [DB_W-1:0]     dbCnt;
  logic                btnSync1, btnSync2, dbLevel, dbPrev;
  logic                autoPrev;
  logic                btnEdge, dwellExpire, adv, dwellClr;

  // Round-robin search for the first valid source after 'from'; the last
  // candidate is 'from' itself so a lone valid source re-selects itself.
  function automatic logic [1:0] nextValid(input logic [3:0] valid, input logic [1:0] from);
    logic [1:0] idx;
    logic       found;
    nextValid = from;
    found     = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = from + 2'(i);
      if (!found && valid[idx]) begin
        nextValid = idx;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Free-running prescaler; toggles scan_clk on every terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scanCnt  <= '0;
      scan_clk <= 1'b0;
    end else if (scanCnt == SCAN_W'(SCAN_DIV - 1)) begin
      scanCnt  <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      scanCnt  <= scanCnt + SCAN_W'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous push-button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnSync1 <= 1'b0;
      btnSync2 <= 1'b0;
    end else begin
      btnSync1 <= btn_next;
      btnSync2 <= btnSync1;
    end
  end

  // Debounce: level follows the synced input only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbCnt   <= '0;
      dbLevel <= 1'b0;
      dbPrev  <= 1'b0;
    end else begin
      dbPrev <= dbLevel;
      if (btnSync2 == dbLevel) begin
        dbCnt <= '0;
      end else if (dbCnt == DB_W'(DB_CYCLES - 1)) begin
        dbCnt   <= '0;
        dbLevel <= btnSync2;
      end else begin
        dbCnt <= dbCnt + DB_W'(1);
      end
    end
  end

  assign btnEdge     = dbLevel & ~dbPrev;
  assign dwellExpire = auto_mode && (state != IDLE) && (dwellCnt == DWELL_W'(DWELL - 1));
  // In auto mode only the timer advances, so a coincident press cannot double-step.
  assign adv         = auto_mode ? dwellExpire : btnEdge;

  // Next-state and next-source selection; losing the current source overrides adv.
  always_comb begin
    stateNext = state;
    srcNext   = cur_src;
    case (state)
      IDLE: begin
        if (|src_valid) begin
          stateNext = SHOW_LO;
          srcNext   = nextValid(src_valid, 2'd3);
        end else begin
          stateNext = IDLE;
        end
      end
      SHOW_LO, SHOW_HI: begin
        if (!src_valid[cur_src]) begin
          if (|src_valid) begin
            stateNext = SHOW_LO;
            srcNext   = nextValid(src_valid, cur_src);
          end else begin
            stateNext = IDLE;
          end
        end else if (adv) begin
          if (state == SHOW_LO) begin
            stateNext = SHOW_HI;
          end else begin
            stateNext = SHOW_LO;
            srcNext   = nextValid(src_valid, cur_src);
          end
        end else begin
          stateNext = state;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and displayed-source registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_src <= 2'd0;
    end else begin
      state   <= stateNext;
      cur_src <= srcNext;
    end
  end

  assign dwellClr = (stateNext != state) || (srcNext != cur_src) || (auto_mode != autoPrev) ||
                    !auto_mode || (state == IDLE);

  // Dwell timer: restarts on every page change or mode change, idle in manual mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwellCnt <= '0;
      autoPrev <= 1'b0;
    end else begin
      autoPrev <= auto_mode;
      if (dwellClr) begin
        dwellCnt <= '0;
      end else if (dwellExpire) begin
        dwellCnt <= '0;
      end else begin
        dwellCnt <= dwellCnt + DWELL_W'(1);
      end
    end
  end

  // Registered driver outputs; data tracks the live value of the selected source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_data <= 32'd0;
      hi_lo     <= 1'b0;
      blank     <= 1'b1;
    end else if (state == IDLE) begin
      disp_data <= 32'd0;
      hi_lo     <= 1'b0;
      blank     <= 1'b1;
    end else begin
      disp_data <= src_data[cur_src*32 +: 32];
      hi_lo     <= (state == SHOW_HI);
      blank     <= 1'b0;
    end
  end

endmodule
